// File: rtl/aclk_pkg.sv
// Shared alarm-clock constants: BCD digit type and per-digit limits for 24-hour time.
package aclk_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t MAX_LS_MIN     = 4'd9;
   localparam bcd_digit_t MAX_MS_MIN     = 4'd5;
   localparam bcd_digit_t MAX_LS_HR      = 4'd9;
   localparam bcd_digit_t MAX_MS_HR      = 4'd2;
   // Highest units-of-hours digit allowed once tens-of-hours reaches 2
   localparam bcd_digit_t MAX_LS_HR_AT_2 = 4'd3;

endpackage

// File: rtl/aclk_time_counter_if.sv
// Bundle between the load controller/time generator and the current-time keeper.
interface aclk_time_counter_if;
   import aclk_pkg::*;

   logic       one_minute;
   logic       load_new_c;
   bcd_digit_t key_buffer_ms_hr;
   bcd_digit_t key_buffer_ls_hr;
   bcd_digit_t key_buffer_ms_min;
   bcd_digit_t key_buffer_ls_min;
   bcd_digit_t current_time_ms_hr;
   bcd_digit_t current_time_ls_hr;
   bcd_digit_t current_time_ms_min;
   bcd_digit_t current_time_ls_min;
   logic       day_rollover;
   logic       load_err;

   modport master (
      output one_minute, load_new_c,
      output key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
      input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
      input  day_rollover, load_err
   );

   modport slave (
      input  one_minute, load_new_c,
      input  key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
      output current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
      output day_rollover, load_err
   );

endinterface

// File: rtl/aclk_bcd_digit.sv
// One modulo-(Limit+1) BCD digit with load, synchronous clear and ripple carry.
module aclk_bcd_digit
   import aclk_pkg::*;
#(
   parameter bcd_digit_t Limit = MAX_LS_MIN
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  bcd_digit_t load_val,
   input  logic       clear,
   input  logic       carry_in,
   output bcd_digit_t digit,
   output logic       carry_out
);

   bcd_digit_t digit_q, digit_d;

   // Next digit: load beats clear beats increment
   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = load_val;
      end else if (clear) begin
         digit_d = '0;
      end else if (carry_in) begin
         digit_d = (digit_q == Limit) ? '0 : digit_q + 4'd1;
      end
   end

   // Digit register
   always_ff @(posedge clk) begin
      if (reset) digit_q <= '0;
      else       digit_q <= digit_d;
   end

   assign digit     = digit_q;
   assign carry_out = carry_in && (digit_q == Limit);

endmodule

// File: rtl/aclk_time_counter.sv
// Current-time keeper: four BCD digits of HH:MM advanced per minute tick, loadable from keys.
module aclk_time_counter
   import aclk_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   aclk_time_counter_if.slave        bus
);

   logic       load_valid;
   logic       load_ok;
   logic       tick;
   logic       ls_min_carry;
   logic       ms_min_carry;
   logic       ls_hr_carry;
   logic       hr_wrap;
   bcd_digit_t ls_min, ms_min, ls_hr;
   bcd_digit_t ms_hr_q, ms_hr_d;
   logic       day_rollover_q, load_err_q;

   // Range check on the keyed-in digits
   always_comb begin
      load_valid = (bus.key_buffer_ms_min <= MAX_MS_MIN) &&
                   (bus.key_buffer_ls_min <= MAX_LS_MIN) &&
                   (bus.key_buffer_ms_hr  <= MAX_MS_HR)  &&
                   (bus.key_buffer_ls_hr  <= MAX_LS_HR)  &&
                   ((bus.key_buffer_ms_hr < MAX_MS_HR) ||
                    (bus.key_buffer_ls_hr <= MAX_LS_HR_AT_2));
   end

   assign load_ok = bus.load_new_c && load_valid;
   // A tick coinciding with any load strobe is dropped
   assign tick    = bus.one_minute && !bus.load_new_c;
   assign hr_wrap = ms_min_carry && (ms_hr_q == MAX_MS_HR) && (ls_hr == MAX_LS_HR_AT_2);

   aclk_bcd_digit #(.Limit(MAX_LS_MIN)) u_ls_min (
      .clk       (clk),
      .reset     (reset),
      .load      (load_ok),
      .load_val  (bus.key_buffer_ls_min),
      .clear     (1'b0),
      .carry_in  (tick),
      .digit     (ls_min),
      .carry_out (ls_min_carry)
   );

   aclk_bcd_digit #(.Limit(MAX_MS_MIN)) u_ms_min (
      .clk       (clk),
      .reset     (reset),
      .load      (load_ok),
      .load_val  (bus.key_buffer_ms_min),
      .clear     (1'b0),
      .carry_in  (ls_min_carry),
      .digit     (ms_min),
      .carry_out (ms_min_carry)
   );

   // On 23 -> 00 the units digit is cleared instead of incremented
   aclk_bcd_digit #(.Limit(MAX_LS_HR)) u_ls_hr (
      .clk       (clk),
      .reset     (reset),
      .load      (load_ok),
      .load_val  (bus.key_buffer_ls_hr),
      .clear     (hr_wrap),
      .carry_in  (ms_min_carry && !hr_wrap),
      .digit     (ls_hr),
      .carry_out (ls_hr_carry)
   );

   // Tens-of-hours next state, including the day wrap
   always_comb begin
      ms_hr_d = ms_hr_q;
      if (load_ok) begin
         ms_hr_d = bus.key_buffer_ms_hr;
      end else if (hr_wrap) begin
         ms_hr_d = '0;
      end else if (ls_hr_carry) begin
         ms_hr_d = ms_hr_q + 4'd1;
      end
   end

   // Tens-of-hours register and the two status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_hr_q        <= '0;
         day_rollover_q <= 1'b0;
         load_err_q     <= 1'b0;
      end else begin
         ms_hr_q        <= ms_hr_d;
         day_rollover_q <= hr_wrap;
         load_err_q     <= bus.load_new_c && !load_valid;
      end
   end

   assign bus.current_time_ms_hr  = ms_hr_q;
   assign bus.current_time_ls_hr  = ls_hr;
   assign bus.current_time_ms_min = ms_min;
   assign bus.current_time_ls_min = ls_min;
   assign bus.day_rollover        = day_rollover_q;
   assign bus.load_err            = load_err_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Scoreboard bench for aclk_time_counter against an integer hour/minute model.
module tb_aclk_time_counter;

   typedef struct packed {
      logic [15:0] t;
      logic        rol;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   m_hr;
   int   m_min;
   int   rol_count;
   exp_t sb_q[$];

   aclk_time_counter_if bus ();

   aclk_time_counter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_bcd(input int hr, input int mn);
      logic [3:0] a, b, c, d;
      a = 4'(hr / 10);
      b = 4'(hr % 10);
      c = 4'(mn / 10);
      d = 4'(mn % 10);
      return {a, b, c, d};
   endfunction

   // One clock: drive inputs, push model expectation, then sample and compare
   task automatic step(input bit rst, input bit tk, input bit ld, input int k3, input int k2,
                       input int k1, input int k0, input string tag);
      exp_t e, got;
      bit   valid;
      logic in_range;
      @(negedge clk);
      reset                 = rst;
      bus.one_minute        = tk;
      bus.load_new_c        = ld;
      bus.key_buffer_ms_hr  = 4'(k3);
      bus.key_buffer_ls_hr  = 4'(k2);
      bus.key_buffer_ms_min = 4'(k1);
      bus.key_buffer_ls_min = 4'(k0);
      e.rol = 1'b0;
      e.err = 1'b0;
      if (rst) begin
         m_hr  = 0;
         m_min = 0;
      end else if (ld) begin
         valid = (k1 <= 5) && (k0 <= 9) && (k3 <= 2) && (k2 <= 9) && ((k3 < 2) || (k2 <= 3));
         if (valid) begin
            m_hr  = k3 * 10 + k2;
            m_min = k1 * 10 + k0;
         end
         e.err = !valid;
      end else if (tk) begin
         m_min++;
         if (m_min == 60) begin
            m_min = 0;
            m_hr++;
            if (m_hr == 24) begin
               m_hr  = 0;
               e.rol = 1'b1;
            end
         end
      end
      e.t = model_bcd(m_hr, m_min);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      got.t   = {bus.current_time_ms_hr, bus.current_time_ls_hr,
                 bus.current_time_ms_min, bus.current_time_ls_min};
      got.rol = bus.day_rollover;
      got.err = bus.load_err;
      if (got.rol === 1'b1) rol_count++;
      check({tag, "_time"}, 32'(got.t), 32'(e.t));
      check({tag, "_rollover"}, 32'(got.rol), 32'(e.rol));
      check({tag, "_load_err"}, 32'(got.err), 32'(e.err));
      in_range = (bus.current_time_ls_min <= 4'd9) && (bus.current_time_ms_min <= 4'd5) &&
                 (bus.current_time_ls_hr <= 4'd9) && (bus.current_time_ms_hr <= 4'd2) &&
                 ((bus.current_time_ms_hr < 4'd2) || (bus.current_time_ls_hr <= 4'd3));
      check({tag, "_range"}, 32'(in_range), 32'd1);
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      m_hr      = 0;
      m_min     = 0;
      rol_count = 0;
      reset                 = 1'b1;
      bus.one_minute        = 1'b0;
      bus.load_new_c        = 1'b0;
      bus.key_buffer_ms_hr  = '0;
      bus.key_buffer_ls_hr  = '0;
      bus.key_buffer_ms_min = '0;
      bus.key_buffer_ls_min = '0;

      step(1, 0, 0, 0, 0, 0, 0, "reset");
      step(0, 0, 1, 1, 4, 3, 7, "load_1437");
      idle("hold_1437");
      step(1, 0, 0, 0, 0, 0, 0, "reset_from_1437");

      step(0, 0, 1, 2, 3, 5, 8, "load_2358");
      step(0, 1, 0, 0, 0, 0, 0, "tick_2359");
      step(0, 1, 0, 0, 0, 0, 0, "tick_0000");
      idle("after_wrap");

      step(0, 0, 1, 0, 9, 5, 9, "load_0959");
      step(0, 1, 0, 0, 0, 0, 0, "tick_1000");
      step(0, 0, 1, 1, 9, 5, 9, "load_1959");
      step(0, 1, 0, 0, 0, 0, 0, "tick_2000");

      step(0, 0, 1, 2, 4, 0, 0, "bad_2400");
      idle("after_bad_2400");
      step(0, 0, 1, 1, 2, 6, 0, "bad_1260");
      step(0, 1, 1, 0, 0, 0, 10, "bad_000a_tick");
      step(0, 0, 1, 3, 0, 0, 0, "bad_3000");

      step(0, 1, 1, 1, 2, 3, 4, "load_tick_1234");
      idle("hold_1234");
      step(1, 1, 1, 1, 2, 3, 4, "reset_load");

      rol_count = 0;
      for (int i = 0; i < 1440; i++) begin
         step(0, 1, 0, 0, 0, 0, 0, "day_tick");
         if ($urandom_range(0, 3) == 0) idle("day_gap");
      end
      check("day_end_time", 32'({bus.current_time_ms_hr, bus.current_time_ls_hr,
                                  bus.current_time_ms_min, bus.current_time_ls_min}), 32'd0);
      check("day_rollover_count", 32'(rol_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
